// File: rtl/input_conditioner_pkg.sv
// Shared constants and button FSM encoding for the input conditioner.
package input_conditioner_pkg;

  localparam int CLK_HZ = 50_000_000;
  // 10 ms of stable input at the system clock rate.
  localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw pushbutton/switch inputs and their conditioned outputs, grouped as one bundle.
interface input_conditioner_if;
  // No valid/ready handshake: raw inputs are asynchronous levels, and every
  // output is a registered level or a single-cycle pulse in the clk domain.
  logic       start_button;
  logic [1:0] switch_raw;
  logic       start_pulse;
  logic       start_level;
  logic [1:0] switch_stable;
  logic       mode_change;

  modport master (
    output start_button,
    output switch_raw,
    input  start_pulse,
    input  start_level,
    input  switch_stable,
    input  mode_change
  );

  modport slave (
    input  start_button,
    input  switch_raw,
    output start_pulse,
    output start_level,
    output switch_stable,
    output mode_change
  );
endinterface

// File: rtl/sync_debounce.sv
// Multi-flop synchronizer followed by a candidate register and a saturating
// stability counter; commit_o flags the cycle a new value has been stable long enough.
module sync_debounce #(
  parameter int               WIDTH           = 1,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  input  logic [WIDTH-1:0] ref_i,
  output logic [WIDTH-1:0] synced_o,
  output logic             commit_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             commit;

  assign synced_o = sync_q[SYNC_STAGES-1];
  assign commit_o = commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // While the input matches the reference the candidate tracks the reference,
  // so any departure always starts a fresh count from zero.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    if (synced_o == ref_i) begin
      cand_d = ref_i;
      cnt_d  = '0;
    end else if (synced_o != cand_q) begin
      cand_d = synced_o;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      commit = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= RESET_VAL;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces the active-low start button (press FSM + pulse) and the 2-bit mode switches.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input_conditioner_if.slave   io,
  output btn_state_e           btn_state_o
);

  logic       btn_synced, btn_commit, btn_ref;
  logic [1:0] sw_synced;
  logic       sw_commit;

  btn_state_e state_q;
  logic       start_pulse_q, start_level_q;
  logic [1:0] switch_stable_q;
  logic       mode_change_q;

  // Reference is the raw level of the debounced state: 1 while released, 0 while pressed.
  assign btn_ref = ~start_level_q;

  sync_debounce #(
    .WIDTH           (1),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (io.start_button),
    .ref_i    (btn_ref),
    .synced_o (btn_synced),
    .commit_o (btn_commit)
  );

  sync_debounce #(
    .WIDTH           (2),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (2'b00)
  ) u_sw (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (io.switch_raw),
    .ref_i    (switch_stable_q),
    .synced_o (sw_synced),
    .commit_o (sw_commit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RELEASED;
      start_pulse_q <= 1'b0;
      start_level_q <= 1'b0;
    end else begin
      start_pulse_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (!btn_synced) state_q <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (btn_synced) begin
            state_q <= RELEASED;
          end else if (btn_commit) begin
            state_q       <= PRESSED;
            start_pulse_q <= 1'b1;
            start_level_q <= 1'b1;
          end
        end
        PRESSED: begin
          if (btn_synced) state_q <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (!btn_synced) begin
            state_q <= PRESSED;
          end else if (btn_commit) begin
            state_q       <= RELEASED;
            start_level_q <= 1'b0;
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_stable_q <= 2'b00;
      mode_change_q   <= 1'b0;
    end else begin
      mode_change_q <= sw_commit;
      if (sw_commit) switch_stable_q <= sw_synced;
    end
  end

  assign io.start_pulse   = start_pulse_q;
  assign io.start_level   = start_level_q;
  assign io.switch_stable = switch_stable_q;
  assign io.mode_change   = mode_change_q;
  assign btn_state_o      = state_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: segment table, hand-built reset sequence and
// random segments, all cross-checked every cycle against a run-length reference model.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  btn_state_e btn_state;

  input_conditioner_if io();

  input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io          (io),
    .btn_state_o (btn_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2 ms");
    $fatal(1);
  end

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_v(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at t=%0t", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // A raw value counts once it has been seen, after the synchronizer delay,
  // for DEB+1 consecutive cycles while differing from the stable value.
  logic [1:0] m_bq[$];
  logic [1:0] m_sq[$];
  logic [1:0] m_b_stable, m_b_val, m_s_stable, m_s_val;
  int         m_b_run, m_s_run;
  logic [4:0] exp_q[$];   // {start_pulse, start_level, switch_stable[1:0], mode_change}

  function automatic void model_reset();
    m_bq.delete();
    m_sq.delete();
    for (int i = 0; i < SYNC; i++) begin
      m_bq.push_back(2'b01);
      m_sq.push_back(2'b00);
    end
    m_b_stable = 2'b01; m_b_val = 2'b01; m_b_run = 0;
    m_s_stable = 2'b00; m_s_val = 2'b00; m_s_run = 0;
    exp_q.delete();
  endfunction

  function automatic void deb(input logic [1:0] s, inout logic [1:0] stable, inout int run,
                              inout logic [1:0] val, output bit fired);
    fired = 1'b0;
    if (s == stable) run = 0;
    else if (run > 0 && s == val) run++;
    else begin
      val = s;
      run = 1;
    end
    if (run == DEB + 1) begin
      stable = s;
      run    = 0;
      fired  = 1'b1;
    end
  endfunction

  function automatic void model_edge();
    logic [1:0] bs, ss;
    bit bf, sf;
    bs = m_bq.pop_front();
    ss = m_sq.pop_front();
    m_bq.push_back({1'b0, io.start_button});
    m_sq.push_back(io.switch_raw);
    deb(bs, m_b_stable, m_b_run, m_b_val, bf);
    deb(ss, m_s_stable, m_s_run, m_s_val, sf);
    exp_q.push_back({bf && (m_b_stable == 2'b00), (m_b_stable == 2'b00), m_s_stable, sf});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [4:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check_v("start_pulse",   2'(io.start_pulse), 2'(e[4]));
    check_v("start_level",   2'(io.start_level), 2'(e[3]));
    check_v("switch_stable", io.switch_stable,   e[2:1]);
    check_v("mode_change",   2'(io.mode_change), 2'(e[0]));
  endtask

  task automatic run_seg(input logic b, input logic [1:0] s, input int cycles,
                         output int np, output int nm, output int fp, output int fm);
    np = 0; nm = 0; fp = -1; fm = -1;
    for (int i = 1; i <= cycles; i++) begin
      io.start_button = b;
      io.switch_raw   = s;
      tick();
      if (io.start_pulse) begin
        np++;
        if (fp < 0) fp = i;
      end
      if (io.mode_change) begin
        nm++;
        if (fm < 0) fm = i;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_v("rst_start_pulse",   2'(io.start_pulse), 2'b00);
    check_v("rst_start_level",   2'(io.start_level), 2'b00);
    check_v("rst_switch_stable", io.switch_stable,   2'b00);
    check_v("rst_mode_change",   2'(io.mode_change), 2'b00);
    check_v("rst_state",         2'(btn_state),      2'(RELEASED));
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic       btn;
    logic [1:0] sw;
    int         cycles;
    int         exp_pulses;
    int         exp_mcs;
    logic       exp_level;
    logic [1:0] exp_stable;
    int         lat_lo;
    int         lat_hi;
    bit         same;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic b, logic [1:0] s, int c, int p, int m,
                              logic lv, logic [1:0] st, int lo, int hi, bit same);
    vec_t v;
    v.name = n; v.btn = b; v.sw = s; v.cycles = c; v.exp_pulses = p; v.exp_mcs = m;
    v.exp_level = lv; v.exp_stable = st; v.lat_lo = lo; v.lat_hi = hi; v.same = same;
    vecs.push_back(v);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int np, nm, fp, fm;
    io.start_button = 1'b1;
    io.switch_raw   = 2'b00;
    model_reset();

    // Press latency: SYNC+DEB = 6 cycles, +/-1 for sampling.
    add("idle",          1'b1, 2'b00,  8, 0, 0, 1'b0, 2'b00, -1, -1, 1'b0);
    add("clean_press",   1'b0, 2'b00, 20, 1, 0, 1'b1, 2'b00,  5,  7, 1'b0);
    add("clean_release", 1'b1, 2'b00, 20, 0, 0, 1'b0, 2'b00, -1, -1, 1'b0);
    for (int k = 0; k < 6; k++)
      add("bounce", logic'(k % 2), 2'b00, 2, 0, 0, 1'b0, 2'b00, -1, -1, 1'b0);
    add("bounce_settle", 1'b0, 2'b00, 12, 1, 0, 1'b1, 2'b00,  5,  7, 1'b0);
    add("hold",          1'b0, 2'b00, 50, 0, 0, 1'b1, 2'b00, -1, -1, 1'b0);
    add("rel_glitch_hi", 1'b1, 2'b00,  3, 0, 0, 1'b1, 2'b00, -1, -1, 1'b0);
    add("rel_glitch_lo", 1'b0, 2'b00,  3, 0, 0, 1'b1, 2'b00, -1, -1, 1'b0);
    add("rel_stable",    1'b1, 2'b00, 12, 0, 0, 1'b0, 2'b00, -1, -1, 1'b0);
    add("sw_to_01",      1'b1, 2'b01, 12, 0, 1, 1'b0, 2'b01, -1, -1, 1'b0);
    add("sw_10_a",       1'b1, 2'b10,  2, 0, 0, 1'b0, 2'b01, -1, -1, 1'b0);
    add("sw_glitch_11",  1'b1, 2'b11,  2, 0, 0, 1'b0, 2'b01, -1, -1, 1'b0);
    add("sw_10_b",       1'b1, 2'b10, 12, 0, 1, 1'b0, 2'b10, -1, -1, 1'b0);
    add("sw_back_00",    1'b1, 2'b00, 12, 0, 1, 1'b0, 2'b00, -1, -1, 1'b0);
    add("simultaneous",  1'b0, 2'b11, 12, 1, 1, 1'b1, 2'b11,  5,  7, 1'b1);

    do_reset(3);

    foreach (vecs[k]) begin
      run_seg(vecs[k].btn, vecs[k].sw, vecs[k].cycles, np, nm, fp, fm);
      check_i({vecs[k].name, "_pulses"}, np, vecs[k].exp_pulses);
      check_i({vecs[k].name, "_mode_changes"}, nm, vecs[k].exp_mcs);
      check_v({vecs[k].name, "_level"}, 2'(io.start_level), 2'(vecs[k].exp_level));
      check_v({vecs[k].name, "_stable"}, io.switch_stable, vecs[k].exp_stable);
      if (vecs[k].lat_lo >= 0)
        check_range({vecs[k].name, "_latency"}, fp, vecs[k].lat_lo, vecs[k].lat_hi);
      if (vecs[k].same)
        check_i({vecs[k].name, "_same_cycle"}, fm, fp);
    end

    // Reset while the press counter sits at 2, with switches held at 11.
    run_seg(1'b1, 2'b11, 12, np, nm, fp, fm);
    check_i("pre_rst_release_pulses", np, 0);
    check_v("pre_rst_level", 2'(io.start_level), 2'b00);
    run_seg(1'b0, 2'b11, 5, np, nm, fp, fm);
    check_v("mid_press_state", 2'(btn_state), 2'(PRESS_WAIT));
    check_i("mid_press_pulses", np, 0);
    io.start_button = 1'b1;
    do_reset(3);
    run_seg(1'b1, 2'b11, 10, np, nm, fp, fm);
    check_i("post_rst_pulses", np, 0);
    check_i("post_rst_mode_changes", nm, 1);
    check_v("post_rst_stable", io.switch_stable, 2'b11);
    run_seg(1'b0, 2'b11, 12, np, nm, fp, fm);
    check_i("fresh_press_pulses", np, 1);
    check_range("fresh_press_latency", fp, 5, 7);
    check_v("fresh_press_level", 2'(io.start_level), 2'b01);

    // Random segments, many shorter than the debounce window.
    for (int seg = 0; seg < 60; seg++) begin
      run_seg(logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              int'($urandom_range(1, 9)), np, nm, fp, fm);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the stable-input time in clk cycles (10 ms at 50 MHz); legal values are >= 2.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth; legal values are >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the 50 MHz system clock, and the only clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_button, input, 1 bit: raw, asynchronous, active-low pushbutton (0 = pressed).
REQ-006 The block SHALL have port switch_raw, input, 2 bits: raw, asynchronous mode switches.
REQ-007 The block SHALL have port start_pulse, output, 1 bit: a single-cycle pulse on each debounced press.
REQ-008 The block SHALL have port start_level, output, 1 bit: the debounced button state (1 = pressed).
REQ-009 The block SHALL have port switch_stable, output, 2 bits: the debounced switch value fed to the mode/LED controller.
REQ-010 The block SHALL have port mode_change, output, 1 bit: a single-cycle pulse whenever switch_stable changes.

Function
REQ-011 start_button and switch_raw SHALL each pass through a SYNC_STAGES-flop synchronizer before any other logic uses them.
REQ-012 Button FSM states SHALL be: RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 In RELEASED, a synced value of 0 SHALL cause a move to PRESS_WAIT and clear the counter.
REQ-014 In PRESS_WAIT, each cycle the synced value is 0 the counter SHALL increment; when the counter reaches DEBOUNCE_CYCLES-1 with the input still 0, the FSM SHALL go to PRESSED.
REQ-015 In PRESS_WAIT, any synced value of 1 SHALL return the FSM to RELEASED with the counter cleared and no pulse.
REQ-016 PRESSED to RELEASE_WAIT to RELEASED SHALL mirror REQ-013 to REQ-015 with input polarity inverted.
REQ-017 start_pulse SHALL be high for exactly the one cycle in which the FSM enters PRESSED.
REQ-018 Holding the button SHALL NOT produce a second pulse; a new pulse requires a debounced release first.
REQ-019 start_level SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 in RELEASED and PRESS_WAIT.
REQ-020 Latency from a clean raw press to start_pulse SHALL be SYNC_STAGES+DEBOUNCE_CYCLES cycles, plus or minus 1 cycle for asynchronous sampling.
REQ-021 The switch path SHALL hold a 2-bit candidate register and its own counter.
REQ-022 In the switch path, when synced equals switch_stable, the counter SHALL be cleared.
REQ-023 In the switch path, when synced differs from switch_stable and differs from the candidate, the candidate SHALL load synced and the counter SHALL clear.
REQ-024 In the switch path, when synced equals the candidate and differs from switch_stable, the counter SHALL increment; at DEBOUNCE_CYCLES-1, switch_stable SHALL load the candidate and mode_change SHALL pulse high for 1 cycle.
REQ-025 A direct 01 to 10 switch transition SHALL produce exactly one update and one mode_change; a transient intermediate value shorter than DEBOUNCE_CYCLES SHALL be ignored.
REQ-026 The button and switch paths SHALL be independent; start_pulse and mode_change may assert in the same cycle, and both SHALL be honoured.
REQ-027 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counters SHALL saturate and never wrap.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_n low SHALL immediately force: button synchronizer flops to 1, switch synchronizer flops and candidate to 00, FSM to RELEASED, both counters to 0, start_pulse 0, start_level 0, switch_stable 00, mode_change 0.
REQ-030 A reset asserted mid-debounce SHALL discard the pending transition, and no pulse SHALL be emitted on reset release.
REQ-031 If switch_raw is nonzero at reset release, switch_stable SHALL update after the normal debounce time, with one mode_change pulse.

Structure
REQ-032 A shared package SHALL hold CLK_HZ (50_000_000), the DEBOUNCE_CYCLES default and the button FSM state encoding.
REQ-033 A single sub-module, sync_debounce (parameters WIDTH, SYNC_STAGES and DEBOUNCE_CYCLES), SHALL implement the synchronizer, candidate and counter logic, instantiated with WIDTH=1 for the button and WIDTH=2 for the switch; the FSM and pulse generation SHALL live in the top level.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-034 Clean press: start_button goes 1 to 0 and is held for 20 cycles -> start_pulse high for exactly 1 cycle, 6 cycles after the edge (plus or minus 1), and start_level goes to 1.
REQ-035 Bounce: start_button toggles 0/1 every 2 cycles for 12 cycles, then is held at 0 -> exactly one start_pulse, occurring after the final stable 4 cycles.
REQ-036 Hold then release: press held for 50 cycles, then release with a 3-cycle glitch, then stable 1 -> one pulse only, and start_level returns to 0 only after 4 stable cycles.
REQ-037 Switch change: switch_raw goes 01 to 10, with a 2-cycle 11 glitch midway -> switch_stable goes 01 to 10 directly, mode_change pulses exactly once, and 11 never appears.
REQ-038 Reset mid-operation: rst_n is pulsed low during PRESS_WAIT (counter=2) -> all outputs are 0 immediately, and no start_pulse appears until a fresh press completes a full debounce.
REQ-039 Simultaneous events: a button press and a switch change 00 to 11 are applied in the same cycle -> start_pulse and mode_change assert in the same cycle, and switch_stable=11.
